control_sequencer: RTL
======================

# control_sequencer

Multi-cycle instruction sequencer for the 10-bit processor, sitting directly upstream of the ALU and register file. It captures a 10-bit instruction on an `Exec` request and steps through up to three control steps (T1–T3). In each step it drives the ALU strobes (`Ain`, `Gin`, `Gout`), the 4-bit ALU function code and the one-hot register-file enables. It signals completion with a one-cycle `Done` pulse.

## Interface
- `NREG`, default 8: number of general registers, which sets the width of `Rin`/`Rout`. Fixed at 8 because the instruction carries 3-bit register fields.
- `W`, default 10: instruction width. Fixed by the ISA.
- `CLKb`  in  1  system clock. All state updates on the falling edge.
- `RSTb`  in  1  reset. Synchronous, active-low, sampled on the falling edge of `CLKb`.
- `Exec`  in  1  start request. Sampled only in IDLE.
- `INSTR`  in  10  instruction: [9:6] opcode/FN, [5:3] Rx (destination and first operand), [2:0] Ry (second operand).
- `IRin`  out  1  instruction-register load strobe.
- `Ain`  out  1  latch bus into the ALU temp register.
- `Gin`  out  1  latch the ALU result into G.
- `Gout`  out  1  drive G onto the bus.
- `ALUcont`  out  4  function code to the ALU.
- `Rin`  out  NREG  one-hot register write enables.
- `Rout`  out  NREG  one-hot register bus-drive enables.
- `ExtOut`  out  1  drive external data (`Din`) onto the bus.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse in the final step of an instruction.
- `Err`  out  1  illegal-opcode flag. See Configuration.

## Operation
- States: IDLE, T1, T2, T3. Outputs are decoded combinationally from the state and IR (Moore on IR).
- IDLE:
  - If `Exec`=1 at a falling edge: IR <= `INSTR`, `IRin`=1 during that cycle, next state T1.
  - If `Exec`=0: stay in IDLE.
- Load (0000):
  - T1: `ExtOut`, `Rin[Rx]`, `Done`.
  - Next state IDLE.
- Copy (0001):
  - T1: `Rout[Ry]`, `Rin[Rx]`, `Done`.
  - Next state IDLE.
- Binary ops (0010 add, 0011 sub, 0110 and, 0111 or, 1000 xor):
  - T1: `Rout[Ry]`, `Ain`.
  - T2: `Rout[Rx]`, `Gin`, `ALUcont`=opcode. The result is Rx op Ry; for sub, Rx−Ry.
  - T3: `Gout`, `Rin[Rx]`, `Done`.
- Unary ops on temp (0100 negate, 0101 invert):
  - T1: `Rout[Rx]`, `Ain`.
  - T2: `Gin`, `ALUcont`=opcode, no bus driver.
  - T3: `Gout`, `Rin[Rx]`, `Done`.
- Shifts (1001 lsl, 1010 lsr, 1011 asr):
  - T1: no strobes.
  - T2: `Rout[Rx]`, `Gin`, `ALUcont`=opcode.
  - T3: `Gout`, `Rin[Rx]`, `Done`.
- Illegal opcodes (1100–1111):
  - T1: no strobes, `Done`=1.
  - Next state IDLE.
- `ALUcont`=0000 outside T2.
- At most one of `Rout`/`ExtOut`/`Gout` is high in any cycle (single bus driver). `Rin` has at most one bit set.
- `Exec` outside IDLE is ignored. `INSTR` changes while busy have no effect.

## Timing
- Reset (`RSTb`=0 at a falling edge, in any state):
  - Next state IDLE, IR=0, `Err`=0.
  - All outputs 0. `Busy`=0, `Done`=0.
  - An instruction in flight is abandoned and no `Rin` fires.
- Latency from the `Exec` edge: load/copy take 2 cycles (IDLE accept + T1); ALU ops take 4 cycles (accept + T1–T3).
- `Done` is high for exactly the final-step cycle. The next falling edge returns to IDLE.
- Back-to-back: with `Exec` held high, the next instruction is accepted at the edge after the return to IDLE, giving one IDLE cycle between instructions.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - An illegal opcode sets `Err` at the T1 edge.
  - `Err` is sticky until reset.
  - While `Err`=1, `Exec` is ignored and the block stays in IDLE.
- Macro undefined:
  - `Err` is tied to 0.
  - Illegal opcodes act as a 2-cycle NOP with `Done`.

## Structure
- Package `proc_pkg`:
  - `alu_fn_e` opcode enum (0000–1011 named).
  - `seq_state_e` (IDLE, T1, T2, T3).
  - Field-position constants `OPC_MSB`/`OPC_LSB`, `RX_LSB`, `RY_LSB`.
- Sub-module `dec3to8`: 3-bit to one-hot-8 decoder with an enable input. It is instantiated twice, once for `Rin` and once for `Rout`.

## Test plan
- Reset mid-instruction: issue add, assert `RSTb`=0 during T2 → next edge: IDLE, all outputs 0, no `Rin` pulse.
- Add R2,R5 (`INSTR`=10'b0010_010_101):
  - T1: `Rout`=8'h20, `Ain`.
  - T2: `Rout`=8'h04, `Gin`, `ALUcont`=0010.
  - T3: `Gout`, `Rin`=8'h04, `Done`.
  - `Busy` is high for 3 cycles.
- Load R7 (10'b0000_111_000) → T1: `ExtOut`=1, `Rin`=8'h80, `Done`; back in IDLE 2 cycles after `Exec`.
- Shift asr R3 (10'b1011_011_000):
  - T1: all strobes 0.
  - T2: `Rout`=8'h08, `Gin`, `ALUcont`=1011.
- Exec held high across two instructions (copy R1←R0, then sub R1,R0) → exactly one IDLE cycle between them; the `INSTR` change during busy is ignored.
- Illegal opcode 10'b1111_000_000:
  - With `ILLEGAL_TRAP_EN`: `Err`=1 and it stays set; a subsequent `Exec` is ignored.
  - Without it: `Done` in T1, `Err`=0.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode, state and instruction-field definitions for the sequencer
package proc_pkg;

   localparam int OPC_MSB = 9;
   localparam int OPC_LSB = 6;
   localparam int RX_LSB  = 3;
   localparam int RY_LSB  = 0;

   typedef enum logic [3:0] {
      FN_LOAD = 4'b0000,
      FN_COPY = 4'b0001,
      FN_ADD  = 4'b0010,
      FN_SUB  = 4'b0011,
      FN_NEG  = 4'b0100,
      FN_INV  = 4'b0101,
      FN_AND  = 4'b0110,
      FN_OR   = 4'b0111,
      FN_XOR  = 4'b1000,
      FN_LSL  = 4'b1001,
      FN_LSR  = 4'b1010,
      FN_ASR  = 4'b1011
   } alu_fn_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T1   = 2'd1,
      T2   = 2'd2,
      T3   = 2'd3
   } seq_state_e;

   // Codes above ASR have no operation behind them.
   function automatic logic is_legal(input logic [3:0] opc);
      return opc <= FN_ASR;
   endfunction

endpackage

// File: rtl/dec3to8.sv
// rtl/dec3to8.sv - 3-bit to one-hot-8 decoder with enable
module dec3to8 (
   input  logic       en,
   input  logic [2:0] sel,
   output logic [7:0] onehot
);

   assign onehot = en ? (8'b0000_0001 << sel) : 8'b0000_0000;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T1..T3 instruction sequencer; ILLEGAL_TRAP_EN makes illegal opcodes a sticky Err trap
module control_sequencer
   import proc_pkg::*;
#(
   parameter int NREG = 8,
   parameter int W    = 10
) (
   input  logic            CLKb,
   input  logic            RSTb,
   input  logic            Exec,
   input  logic [W-1:0]    INSTR,
   output logic            IRin,
   output logic            Ain,
   output logic            Gin,
   output logic            Gout,
   output logic [3:0]      ALUcont,
   output logic [NREG-1:0] Rin,
   output logic [NREG-1:0] Rout,
   output logic            ExtOut,
   output logic            Busy,
   output logic            Done,
   output logic            Err
);

   seq_state_e state, next;
   logic [W-1:0] ir;
   logic         err_q;
   logic [3:0]   opc;
   logic [2:0]   rx, ry;
   logic         rin_en, rout_en;
   logic [2:0]   rout_sel;

   assign opc = ir[OPC_MSB:OPC_LSB];
   assign rx  = ir[RX_LSB+2:RX_LSB];
   assign ry  = ir[RY_LSB+2:RY_LSB];

   always_ff @(negedge CLKb) begin
      if (!RSTb) begin
         state <= IDLE;
         ir    <= '0;
      end else begin
         state <= next;
         if (IRin) ir <= INSTR;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   always_ff @(negedge CLKb) begin
      if (!RSTb)
         err_q <= 1'b0;
      else if (state == T1 && !is_legal(opc))
         err_q <= 1'b1;
   end
`else
   assign err_q = 1'b0;
`endif

   always_comb begin
      next     = state;
      IRin     = 1'b0;
      Ain      = 1'b0;
      Gin      = 1'b0;
      Gout     = 1'b0;
      ALUcont  = 4'b0000;
      ExtOut   = 1'b0;
      Done     = 1'b0;
      rin_en   = 1'b0;
      rout_en  = 1'b0;
      rout_sel = ry;
      case (state)
         IDLE: begin
            if (Exec && !err_q) begin
               IRin = 1'b1;
               next = T1;
            end
         end
         T1: begin
            next = T2;
            case (opc)
               FN_LOAD: begin
                  ExtOut = 1'b1;
                  rin_en = 1'b1;
                  Done   = 1'b1;
                  next   = IDLE;
               end
               FN_COPY: begin
                  rout_en = 1'b1;
                  rin_en  = 1'b1;
                  Done    = 1'b1;
                  next    = IDLE;
               end
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR: begin
                  rout_en = 1'b1;
                  Ain     = 1'b1;
               end
               // Unary ops load Rx into the temp; the ALU then works on the temp alone.
               FN_NEG, FN_INV: begin
                  rout_en  = 1'b1;
                  rout_sel = rx;
                  Ain      = 1'b1;
               end
               FN_LSL, FN_LSR, FN_ASR: ;
               default: begin
                  Done = 1'b1;
                  next = IDLE;
               end
            endcase
         end
         T2: begin
            Gin      = 1'b1;
            ALUcont  = opc;
            rout_sel = rx;
            rout_en  = !(opc == FN_NEG || opc == FN_INV);
            next     = T3;
         end
         T3: begin
            Gout   = 1'b1;
            rin_en = 1'b1;
            Done   = 1'b1;
            next   = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   assign Busy = (state != IDLE);
   assign Err  = err_q;

   dec3to8 u_rin_dec (
      .en     (rin_en),
      .sel    (rx),
      .onehot (Rin)
   );

   dec3to8 u_rout_dec (
      .en     (rout_en),
      .sel    (rout_sel),
      .onehot (Rout)
   );

endmodule
